// File: rtl/id_operand_stage_pkg.sv
// Shared constants for the ID operand stage: stall-vector indices, MIPS opcode/funct
// encodings and forwarding-bus slice helpers.
package id_operand_stage_pkg;

  localparam int unsigned ID_IN  = 1;
  localparam int unsigned ID_OUT = 2;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  localparam logic [4:0] RI_BLTZ = 5'h00;
  localparam logic [4:0] RI_BGEZ = 5'h01;

  // Channel k of a packed forwarding bus occupies [fwd_lsb(k, w) +: w].
  function automatic int fwd_lsb(int k, int w);
    return k * w;
  endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// Forwarding bus from the EX/MEM/WB result ports into the ID operand stage.
interface id_operand_stage_if #(
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned RA_W    = 5,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_FWD-1:0]        fwd_we;
  logic [NUM_FWD*RA_W-1:0]   fwd_waddr;
  logic [NUM_FWD*DATA_W-1:0] fwd_wdata;
  logic [NUM_FWD-1:0]        fwd_is_load;

  modport master (output fwd_we, output fwd_waddr, output fwd_wdata, output fwd_is_load);
  modport slave  (input fwd_we, input fwd_waddr, input fwd_wdata, input fwd_is_load);
endinterface

// File: rtl/id_fwd_mux.sv
// Resolves one source operand: register 0, youngest matching forwarding channel, or
// the register file, and reports whether the winning producer is a load still in flight.
module id_fwd_mux
  import id_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RA_W    = 5,
  parameter int unsigned NUM_FWD = 3
) (
  input  logic [RA_W-1:0]           raddr,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*RA_W-1:0]   fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  input  logic [DATA_W-1:0]         rf_rdata,
  output logic [DATA_W-1:0]         data,
  output logic                      hit_is_load
);

  always_comb begin
    data        = rf_rdata;
    hit_is_load = 1'b0;
    // Walk oldest to youngest so the lowest matching index wins.
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_we[k] && (fwd_waddr[fwd_lsb(k, RA_W) +: RA_W] == raddr)) begin
        data        = fwd_wdata[fwd_lsb(k, DATA_W) +: DATA_W];
        hit_is_load = fwd_is_load[k];
      end
    end
    if (raddr == '0) begin
      data        = '0;
      hit_is_load = 1'b0;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// IF->ID pipeline register with SRAM word buffering, operand forwarding, load-use
// interlock and in-ID branch/jump resolution (delay-slot semantics, no flush).
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned RA_W    = 5,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                if_valid,
  input  logic [PC_W-1:0]     if_pc,
  input  logic [31:0]         inst_rdata,
  output logic [RA_W-1:0]     rf_raddr1,
  output logic [RA_W-1:0]     rf_raddr2,
  input  logic [DATA_W-1:0]   rf_rdata1,
  input  logic [DATA_W-1:0]   rf_rdata2,
  id_operand_stage_if.slave   fwd_bus,
  output logic                id_valid,
  output logic [PC_W-1:0]     id_pc,
  output logic [31:0]         id_inst,
  output logic [DATA_W-1:0]   rs_data,
  output logic [DATA_W-1:0]   rt_data,
  output logic                stallreq,
  output logic                br_taken,
  output logic [PC_W-1:0]     br_target,
  output logic [CNT_W-1:0]    lu_stall_cnt
);

  logic        buf_vld;
  logic [31:0] inst_buf;
  logic        do_load, do_bubble;

  logic unused_stall;
  assign unused_stall = ^{stall[STALL_W-1:3], stall[0]};

  assign do_bubble = (stall[ID_IN] == Stop) && (stall[ID_OUT] == NoStop);
  assign do_load   = (stall[ID_IN] == NoStop);

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
    end else if (do_bubble) begin
      id_valid <= 1'b0;
    end else if (do_load) begin
      id_valid <= if_valid;
      id_pc    <= if_pc;
    end
  end

  // The SRAM word only lives one cycle; latch it on the first stalled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld  <= 1'b0;
      inst_buf <= '0;
    end else if (do_bubble || do_load) begin
      buf_vld <= 1'b0;
    end else if (!buf_vld) begin
      buf_vld  <= 1'b1;
      inst_buf <= id_inst;
    end
  end

  assign id_inst = id_valid ? (buf_vld ? inst_buf : inst_rdata) : 32'h0;

  logic [5:0]  op, funct;
  logic [4:0]  rs_f, rt_f;
  logic [15:0] imm;
  logic [25:0] idx;
  logic        is_rtype, is_shift_imm;
  logic        rs_used, rt_used;

  assign op    = id_inst[31:26];
  assign rs_f  = id_inst[25:21];
  assign rt_f  = id_inst[20:16];
  assign imm   = id_inst[15:0];
  assign idx   = id_inst[25:0];
  assign funct = id_inst[5:0];

  assign rf_raddr1 = id_inst[21 +: RA_W];
  assign rf_raddr2 = id_inst[16 +: RA_W];

  assign is_rtype     = (op == OP_SPECIAL);
  assign is_shift_imm = is_rtype && ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA));

  assign rs_used = id_valid && (id_inst != 32'h0) && (op != OP_J) && (op != OP_JAL) &&
                   (op != OP_LUI) && !is_shift_imm;
  assign rt_used = id_valid && (is_rtype || (op == OP_BEQ) || (op == OP_BNE) ||
                   (op == OP_SW) || (op == OP_SH) || (op == OP_SB));

  logic rs_hit_load, rt_hit_load;

  id_fwd_mux #(
    .DATA_W  (DATA_W),
    .RA_W    (RA_W),
    .NUM_FWD (NUM_FWD)
  ) u_rs_mux (
    .raddr       (rf_raddr1),
    .fwd_we      (fwd_bus.fwd_we),
    .fwd_waddr   (fwd_bus.fwd_waddr),
    .fwd_wdata   (fwd_bus.fwd_wdata),
    .fwd_is_load (fwd_bus.fwd_is_load),
    .rf_rdata    (rf_rdata1),
    .data        (rs_data),
    .hit_is_load (rs_hit_load)
  );

  id_fwd_mux #(
    .DATA_W  (DATA_W),
    .RA_W    (RA_W),
    .NUM_FWD (NUM_FWD)
  ) u_rt_mux (
    .raddr       (rf_raddr2),
    .fwd_we      (fwd_bus.fwd_we),
    .fwd_waddr   (fwd_bus.fwd_waddr),
    .fwd_wdata   (fwd_bus.fwd_wdata),
    .fwd_is_load (fwd_bus.fwd_is_load),
    .rf_rdata    (rf_rdata2),
    .data        (rt_data),
    .hit_is_load (rt_hit_load)
  );

  // The mux already suppresses hits on register 0.
  assign stallreq = id_valid && ((rs_used && rs_hit_load) || (rt_used && rt_hit_load));

  logic            cond;
  logic [PC_W-1:0] pc4, br_off, target;
  logic            rs_neg, rs_zero;

  assign rs_neg  = rs_data[DATA_W-1];
  assign rs_zero = (rs_data == '0);

  always_comb begin
    pc4    = id_pc + PC_W'(4);
    br_off = {{(PC_W - 18){imm[15]}}, imm, 2'b00};
    cond   = 1'b0;
    target = pc4 + br_off;
    case (op)
      OP_SPECIAL: begin
        if ((funct == FN_JR) || (funct == FN_JALR)) begin
          cond   = 1'b1;
          target = PC_W'(rs_data);
        end
      end
      OP_J, OP_JAL: begin
        cond   = 1'b1;
        target = {pc4[PC_W-1:28], idx, 2'b00};
      end
      OP_BEQ:    cond = (rs_data == rt_data);
      OP_BNE:    cond = (rs_data != rt_data);
      OP_BLEZ:   cond = rs_neg || rs_zero;
      OP_BGTZ:   cond = !rs_neg && !rs_zero;
      OP_REGIMM: begin
        if (rt_f == RI_BLTZ)      cond = rs_neg;
        else if (rt_f == RI_BGEZ) cond = !rs_neg;
      end
      default:   cond = 1'b0;
    endcase
  end

  assign br_taken  = id_valid && !stallreq && cond;
  assign br_target = br_taken ? target : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_stall_cnt <= '0;
    end else if (stallreq && (lu_stall_cnt != '1)) begin
      lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Parametrised next-generation decode-front block that sits between IF and EX.
- Holds the IF→ID pipeline register and buffers the synchronous-SRAM instruction word across stalls.
- Resolves rs/rt operands from the register file plus NUM_FWD forwarding channels, with age-ordered priority.
- Detects load-use hazards to raise stallreq, and resolves branches/jumps in ID (MIPS delay-slot semantics, no flush).

Parameters:
- DATA_W, 32, operand/datapath width.
- PC_W, 32, program-counter width.
- RA_W, 5, register address width (register 0 hardwired zero).
- NUM_FWD, 3, forwarding channels; index 0 is youngest (EX), then MEM, then WB.
- STALL_W, 6, width of the stall vector.
- CNT_W, 32, width of the load-use stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- stall  in  STALL_W  stall[1]=1 holds the ID input, stall[2]=1 holds the ID output.
- if_valid  in  1  IF presents a valid pc this cycle.
- if_pc  in  PC_W  fetch pc.
- inst_rdata  in  32  SRAM data; valid the cycle after its pc is captured.
- rf_raddr1 / rf_raddr2  out  RA_W  regfile read addresses (rs, rt).
- rf_rdata1 / rf_rdata2  in  DATA_W  combinational regfile read data.
- fwd_we  in  NUM_FWD  per-channel write enable.
- fwd_waddr  in  NUM_FWD*RA_W  per-channel destination address, channel k at [k*RA_W +: RA_W].
- fwd_wdata  in  NUM_FWD*DATA_W  per-channel result data.
- fwd_is_load  in  NUM_FWD  channel result is not yet available (load in flight).
- id_valid  out  1  ID holds a valid instruction.
- id_pc  out  PC_W  pc of the ID instruction.
- id_inst  out  32  instruction word (0 when !id_valid).
- rs_data / rt_data  out  DATA_W  resolved operands.
- stallreq  out  1  load-use interlock request.
- br_taken  out  1  redirect fetch.
- br_target  out  PC_W  redirect address.
- lu_stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset: id_valid=0, id_pc=0, buffer-valid flag buf_vld=0, inst_buf=0, lu_stall_cnt=0. All outputs derive from these, so id_inst=0, br_taken=0, stallreq=0 the cycle after reset.
- Pipe register priority: rst > (stall[1]=1 & stall[2]=0 → bubble: id_valid=0) > (stall[1]=0 → load if_valid/if_pc) > hold.
- Instruction buffer:
  - id_inst = buf_vld ? inst_buf : inst_rdata, masked to 0 when !id_valid.
  - On any cycle with stall[1]=1 and buf_vld=0, capture inst_buf <= id_inst and set buf_vld=1.
  - Clear buf_vld on load, bubble or rst.
  - Result: the word survives multi-cycle stalls even though the SRAM output changes.
- Decode (combinational):
  - rs_used for all valid instructions except j, jal, lui, sll/srl/sra, and all-zero (nop).
  - rt_used for R-type, beq, bne, sw/sh/sb.
- Operand resolution (per source, raddr = rs or rt):
  - raddr=0 → 0.
  - Otherwise the lowest channel k with fwd_we[k] & fwd_waddr[k]==raddr supplies fwd_wdata[k].
  - If no channel matches, rf_rdata is used.
  - Multiple channels may match; only the lowest index counts.
- Load-use: stallreq=1 iff id_valid and, for a used source with raddr≠0, the winning channel has fwd_is_load=1. Purely combinational, same cycle.
- Branches: br_taken = id_valid & ~stallreq & cond. Targets:
  - beq/bne/bgez/bltz/blez/bgtz: pc+4+(sext(imm)<<2), with conditions evaluated on the resolved operands.
  - j/jal: {pc+4[31:28], index, 2'b00}.
  - jr/jalr: rs_data.
  - br_target=0 when br_taken=0.
- Counter: lu_stall_cnt increments each cycle stallreq=1 and saturates at all-ones; cleared only by rst.
- Reset mid-stall: buffer and counter clear, and the next valid instruction is loaded normally.

Decomposition:
- Shared package holds:
  - stall-index constants (ID_IN=1, ID_OUT=2), Stop/NoStop;
  - opcode/funct localparams;
  - forwarding-bus slice helpers.
- One sub-module, id_fwd_mux, resolves a single operand (address, channels, regfile data → data, hit_is_load). It is instantiated twice.

Test Plan:
- Forward priority: rs=5; ch0 we=1 addr=5 data=0x11; ch2 we=1 addr=5 data=0x33 → rs_data=0x11.
- Register 0: rs=0 with ch0 addr=0 data=0xFFFF_FFFF → rs_data=0, stallreq=0.
- Load-use: addu rd,r3,r4 with ch0 addr=4 is_load=1 → stallreq=1 and lu_stall_cnt +1 per stall cycle. Then drop is_load and set ch1 addr=4 data=7 → stallreq=0, rt_data=7.
- Instruction buffer: stall[1]=stall[2]=1 for 3 cycles while inst_rdata changes from 0x24020005 to 0xDEADBEEF → id_inst stays 0x24020005; after release the next word loads.
- Bubble: stall[1]=1, stall[2]=0 → next cycle id_valid=0, id_inst=0, br_taken=0.
- Branches:
  - beq at pc 0x1000 with imm=0x0003 and equal operands → br_taken=1, br_target=0x1010.
  - Same with stallreq=1 → br_taken=0.
  - jr r31 where forwarded value is 0x2000 → br_target=0x2000.
